// File: rtl/hex_display_arbiter.sv
// hex_display_arbiter
//   Shares the six board seven-segment displays (HEX0..HEX5) among N_REQ
//   on-chip requesters. Digit-write requests are arbitrated round-robin
//   (at most one grant per cycle) into a 6-entry digit store; the HEX outputs
//   are an active-low combinational decode of that store.
//
// Ports
//   CLOCK_50  in   system clock, all state on the rising edge
//   reset     in   synchronous, active-high reset
//   req       in   [N_REQ]   per-requester write request (level, held until ack)
//   req_idx   in   [3*N_REQ] digit index of requester i at [3i+2:3i] (0..5 valid)
//   req_val   in   [4*N_REQ] hex value of requester i at [4i+3:4i]
//   req_blank in   [N_REQ]   1 = blank the indexed digit, req_val ignored
//   ack       out  [N_REQ]   one-cycle grant pulse, one-hot or zero
//   err       out            one-cycle pulse with the ack when the index was 6/7
//   HEX0..5   out  [7] each  active-low segments, bit0 = a .. bit6 = g
module hex_display_arbiter #(
  parameter int N_REQ = 3
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [3*N_REQ-1:0] req_idx,
  input  logic [4*N_REQ-1:0] req_val,
  input  logic [N_REQ-1:0]   req_blank,
  output logic [N_REQ-1:0]   ack,
  output logic               err,
  output logic [6:0]         HEX0,
  output logic [6:0]         HEX1,
  output logic [6:0]         HEX2,
  output logic [6:0]         HEX3,
  output logic [6:0]         HEX4,
  output logic [6:0]         HEX5
);

  localparam int LW = $clog2(N_REQ);

  typedef logic [LW-1:0] req_id_t;

  typedef struct packed {
    logic       blank;
    logic [3:0] val;
  } digit_t;

  // Registered state
  logic [N_REQ-1:0] ack_q,  ack_d;
  logic             err_q,  err_d;
  req_id_t          last_q, last_d;
  digit_t           store_q [6];
  digit_t           store_d [6];

  // Grant-select results
  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt_oh;
  logic             gnt_valid;
  req_id_t          gnt_id;
  logic [2:0]       gnt_idx;
  logic [3:0]       gnt_val;
  logic             gnt_blank;

  // Active-low segment decode; a blank entry turns every segment off.
  function automatic logic [6:0] seg7(input digit_t d);
    logic [6:0] s;
    unique case (d.val)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return d.blank ? 7'h7F : s;
  endfunction

  // Round-robin grant select. A requester whose ack is high this cycle is
  // not eligible, which also limits each requester to one write per 2 cycles.
  // The first pass looks only above last_grant; if it finds nothing, the
  // second pass takes the lowest eligible index, which completes the wrap.
  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so
    // no path leaves it unassigned and infers a latch.
    elig      = req & ~ack_q;
    gnt_valid = 1'b0;
    gnt_oh    = '0;
    gnt_id    = '0;
    gnt_idx   = '0;
    gnt_val   = '0;
    gnt_blank = 1'b0;
    for (int c = 0; c < N_REQ; c++) begin
      if (!gnt_valid && elig[c] && (req_id_t'(c) > last_q)) begin
        gnt_valid = 1'b1;
        gnt_oh[c] = 1'b1;
        gnt_id    = req_id_t'(c);
        gnt_idx   = req_idx[3*c +: 3];
        gnt_val   = req_val[4*c +: 4];
        gnt_blank = req_blank[c];
      end
    end
    for (int c = 0; c < N_REQ; c++) begin
      if (!gnt_valid && elig[c]) begin
        gnt_valid = 1'b1;
        gnt_oh[c] = 1'b1;
        gnt_id    = req_id_t'(c);
        gnt_idx   = req_idx[3*c +: 3];
        gnt_val   = req_val[4*c +: 4];
        gnt_blank = req_blank[c];
      end
    end
  end

  // Next-state: ack/err are single-cycle pulses, the store only changes on a
  // grant with an in-range index.
  always_comb begin
    ack_d   = gnt_oh;
    err_d   = 1'b0;
    last_d  = last_q;
    store_d = store_q;
    if (gnt_valid) begin
      last_d = gnt_id;
      if (gnt_idx > 3'd5) begin
        err_d = 1'b1;
      end else begin
        for (int e = 0; e < 6; e++) begin
          if (gnt_idx == 3'(e)) begin
            store_d[e] = '{blank: gnt_blank, val: gnt_val};
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      ack_q  <= '0;
      err_q  <= 1'b0;
      last_q <= req_id_t'(N_REQ - 1);
      // NOTE: the digit store is reset, unlike a typical RAM, because the
      // displays must come up blank rather than showing garbage.
      for (int e = 0; e < 6; e++) begin
        store_q[e] <= '{blank: 1'b1, val: 4'h0};
      end
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      last_q <= last_d;
      for (int e = 0; e < 6; e++) begin
        store_q[e] <= store_d[e];
      end
    end
  end

  assign ack  = ack_q;
  assign err  = err_q;
  assign HEX0 = seg7(store_q[0]);
  assign HEX1 = seg7(store_q[1]);
  assign HEX2 = seg7(store_q[2]);
  assign HEX3 = seg7(store_q[3]);
  assign HEX4 = seg7(store_q[4]);
  assign HEX5 = seg7(store_q[5]);

endmodule

// File: tb/tb_hex_display_arbiter.sv
// tb_hex_display_arbiter
//   Directed scenarios followed by constrained-random traffic for
//   hex_display_arbiter (N_REQ = 3). Expected values come from a small
//   cycle model of the arbitration rules and the digit-store contents.
module tb_hex_display_arbiter;

  localparam int N = 3;

  localparam logic [6:0] SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [3*N-1:0] req_idx;
  logic [4*N-1:0] req_val;
  logic [N-1:0]   req_blank;
  logic [N-1:0]   ack;
  logic           err;
  logic [6:0]     HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [6:0]     hex [6];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [N-1:0] m_ack   = '0;
  logic         m_err   = 1'b0;
  int           m_last  = N - 1;
  bit           m_blank [6];
  int           m_val   [6];

  always #5 clk = ~clk;

  assign hex[0] = HEX0;
  assign hex[1] = HEX1;
  assign hex[2] = HEX2;
  assign hex[3] = HEX3;
  assign hex[4] = HEX4;
  assign hex[5] = HEX5;

  hex_display_arbiter #(.N_REQ(N)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .req       (req),
    .req_idx   (req_idx),
    .req_val   (req_val),
    .req_blank (req_blank),
    .ack       (ack),
    .err       (err),
    .HEX0      (HEX0),
    .HEX1      (HEX1),
    .HEX2      (HEX2),
    .HEX3      (HEX3),
    .HEX4      (HEX4),
    .HEX5      (HEX5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of the behavioural model, using the inputs present at the edge.
  task automatic model_update();
    logic [N-1:0] elig;
    int           w;
    int           idx;
    if (reset) begin
      for (int d = 0; d < 6; d++) begin
        m_blank[d] = 1'b1;
        m_val[d]   = 0;
      end
      m_ack  = '0;
      m_err  = 1'b0;
      m_last = N - 1;
      return;
    end
    elig = req & ~m_ack;
    w    = -1;
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (m_last + k) % N;
      if (w < 0 && elig[c]) w = c;
    end
    m_ack = '0;
    m_err = 1'b0;
    if (w >= 0) begin
      m_ack[w] = 1'b1;
      m_last   = w;
      idx      = int'(req_idx[3*w +: 3]);
      if (idx <= 5) begin
        m_blank[idx] = req_blank[w];
        m_val[idx]   = int'(req_val[4*w +: 4]);
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic check_model();
    check("ack", 32'(ack), 32'(m_ack));
    check("err", 32'(err), 32'(m_err));
    for (int d = 0; d < 6; d++) begin
      check($sformatf("HEX%0d", d), 32'(hex[d]),
            32'(m_blank[d] ? 7'h7F : SEG[m_val[d]]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic set_req(input int i, input bit r, input int idx, input int val, input bit blank);
    req[i]            = r;
    req_idx[3*i +: 3] = 3'(idx);
    req_val[4*i +: 4] = 4'(val);
    req_blank[i]      = blank;
  endtask

  initial begin
    logic [N-1:0] prev_ack;
    reset     = 1'b1;
    req       = '0;
    req_idx   = '0;
    req_val   = '0;
    req_blank = '0;
    step();
    step();
    reset = 1'b0;

    // Idle after reset: everything blank, no pulses.
    for (int c = 0; c < 10; c++) begin
      step();
      check("idle_ack", 32'(ack), 32'(0));
      check("idle_err", 32'(err), 32'(0));
      for (int d = 0; d < 6; d++) check($sformatf("idle_HEX%0d", d), 32'(hex[d]), 32'h7F);
    end

    // Single write, dropped at ack.
    set_req(0, 1'b1, 2, 5, 1'b0);
    step();
    check("single_ack", 32'(ack), 32'b001);
    check("single_HEX2", 32'(HEX2), 32'h12);
    req[0] = 1'b0;
    step();
    check("single_noack", 32'(ack), 32'(0));
    check("single_HEX0", 32'(HEX0), 32'h7F);
    check("single_HEX5", 32'(HEX5), 32'h7F);

    // Out-of-range index: ack with err, store untouched.
    set_req(1, 1'b1, 6, 3, 1'b0);
    step();
    check("err_ack", 32'(ack), 32'b010);
    check("err_err", 32'(err), 32'(1));
    check("err_HEX2", 32'(HEX2), 32'h12);
    check("err_HEX0", 32'(HEX0), 32'h7F);
    req[1] = 1'b0;
    step();

    // Write, blank, overwrite the same digit.
    set_req(2, 1'b1, 0, 10, 1'b0);
    step();
    check("ovw_A", 32'(HEX0), 32'h08);
    req[2] = 1'b0;
    step();
    set_req(2, 1'b1, 0, 3, 1'b1);
    step();
    check("ovw_blank", 32'(HEX0), 32'h7F);
    req[2] = 1'b0;
    step();
    set_req(2, 1'b1, 0, 15, 1'b0);
    step();
    check("ovw_F", 32'(HEX0), 32'h0E);
    req[2] = 1'b0;
    step();

    // Round-robin from reset with all requesters held high.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3 + i, i + 1, 1'b0);
    prev_ack = '0;
    for (int c = 0; c < 9; c++) begin
      step();
      check($sformatf("rr_ack%0d", c), 32'(ack), 32'(1 << (c % N)));
      check($sformatf("rr_noback%0d", c), 32'(ack & prev_ack), 32'(0));
      prev_ack = ack;
    end

    // Reset with requests pending and digits populated.
    req[2] = 1'b0;
    reset  = 1'b1;
    step();
    check("rst_ack", 32'(ack), 32'(0));
    for (int d = 0; d < 6; d++) check($sformatf("rst_HEX%0d", d), 32'(hex[d]), 32'h7F);
    reset = 1'b0;
    step();
    check("rst_first", 32'(ack), 32'b001);
    req = '0;
    step();

    // Random traffic obeying the hold-until-ack rule, with withdrawals,
    // out-of-range indices and occasional resets.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && !m_ack[i]) begin
          if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else begin
          set_req(i, $urandom_range(0, 2) != 0, int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), $urandom_range(0, 3) == 0);
        end
      end
      reset = ($urandom_range(0, 99) == 0);
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hex_display_arbiter.md
# hex_display_arbiter

Shares the six DE-series seven-segment displays (HEX0–HEX5) among several on-chip requesters. It round-robin arbitrates digit-write requests and holds a 6-entry digit store. It drives active-low segment patterns straight to the board HEX ports. It sits between user logic inside `top` and the board-level HEX outputs.

## Interface
- `N_REQ`, default 3: number of requesters, 2–8.
- `CLOCK_50` in 1: 50 MHz system clock; all state on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req` in N_REQ: per-requester write request (level).
- `req_idx` in 3*N_REQ: digit index for requester i, at bits [3i+2:3i]; valid 0–5 (0 = HEX0).
- `req_val` in 4*N_REQ: hex value for requester i, at bits [4i+3:4i].
- `req_blank` in N_REQ: 1 = blank the indexed digit; `req_val` is ignored.
- `ack` out N_REQ: one-cycle grant/complete pulse, one-hot or zero.
- `err` out 1: one-cycle pulse; the acked request had index 6 or 7.
- `HEX0`…`HEX5` out 7 each: active-low segments, bit0 = a … bit6 = g.

## Operation
- Digit store: 6 entries, each {blank, val[3:0]}. HEX outputs are a combinational decode of the store.
- Decode, active-low, for values 0–F:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
  - blank = 7F
- Arbitration, every cycle:
  - Eligible = `req & ~ack`. A requester is not eligible in the cycle its ack is high.
  - Search starts at `(last_grant+1) mod N_REQ` and proceeds upward with wrap. The first eligible requester wins.
  - At most one grant per cycle.
- On a grant to requester i at the edge ending cycle t:
  - `ack[i]` = 1 during cycle t+1.
  - `last_grant` ← i.
  - If `req_idx` ≤ 5: the store entry is written with {req_blank, req_val}, and `err` = 0.
  - Otherwise: no store write, and `err` = 1 during t+1, coincident with the ack.
- With no eligible requester: `ack` = 0, `err` = 0, and `last_grant` is unchanged.
- Requester rules:
  - Hold `req`, `req_idx`, `req_val` and `req_blank` stable from assertion until the cycle ack is seen.
  - If `req` is still high in the cycle after ack, it is a new request, eligible from that cycle on.
  - Deasserting `req` before ack withdraws the request; nothing is written.
- Each requester gets at most one write per 2 cycles. The aggregate rate is 1 write per cycle when 2 or more requesters are active.
- Different requesters may write the same index in consecutive cycles; the last write wins. Writes never merge.

## Timing
- Reset (synchronous; takes effect at the first rising edge with `reset`=1):
  - All store entries blank, so all HEX outputs = 7F.
  - `ack` = 0, `err` = 0.
  - `last_grant` = N_REQ−1, so requester 0 has first priority.
- `reset` overrides any grant in the same cycle. No ack is issued for a request present during reset.
- Request-to-ack latency: 1 cycle for an uncontended request sampled in cycle t; ack is visible in t+1.
- Request-to-HEX latency: 1 cycle. The new segment pattern is visible in t+1, together with the ack.
- Worst-case wait for a continuously asserted request: N_REQ−1 grants to others, i.e. ack no later than t+N_REQ.
- Everything is registered except the HEX decode and the grant-select logic.

## Test plan
- Reset, no requests:
  - HEX0–HEX5 = 7F, `ack` = 0, `err` = 0 for 10 cycles.
- Single write: req0 with idx 2, val 5, blank 0.
  - `ack` = 001 the next cycle, and HEX2 = 12 in that same cycle.
  - Req0 dropped at ack: no second ack, and the other HEX outputs stay 7F.
- Round-robin: req = 111 held continuously, each requester writing its own distinct digit.
  - Ack sequence from reset: 001, 010, 100, 001, …; exactly one ack per cycle.
  - No requester is acked in 2 consecutive cycles.
- Error path: req1 with idx 6.
  - `ack` = 010 and `err` = 1 in the same cycle; all HEX outputs unchanged.
- Blank and overwrite:
  - Write idx 0 val A: HEX0 = 08.
  - Then write idx 0 with blank = 1: HEX0 = 7F.
  - Then write idx 0 val F: HEX0 = 0E.
- Reset mid-operation: assert `reset` while req = 011 and digits are populated.
  - The following cycle: `ack` = 0 and all HEX = 7F.
  - After release, the first grant goes to requester 0.
